tri_64x144_fifo_ctl: RTL and testbench

Initiator/controller that owns both ports of a 64x144 1r1w register-file array. It turns that array into a 144-bit valid/ready FIFO.
- Write side: drives write_enable/addr_wr/data_in from a push interface.
- Read side: issues rd_act/addr_rd, tracks the fixed 2-cycle array read latency and lands returned data in a small prefetch buffer feeding the pop interface.
- Sits between a producer pipeline and a consumer, e.g. an L2 reload or store-data queue.

---
 rtl/tri_64x144_fifo_ctl_pkg.sv | 25 ++
 rtl/tri_fifo_ctl_pfbuf.sv | 52 +++++
 rtl/tri_64x144_fifo_ctl.sv | 109 ++++++++++
 tb/tb_tri_64x144_fifo_ctl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_64x144_fifo_ctl_pkg.sv
// Shared sizing for the 64x144 register-file FIFO controller and its prefetch buffer.
// Also holds the wrap-bit pointer compares.
package tri_64x144_fifo_ctl_pkg;

    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int WIDTH  = 144;
    localparam int RD_LAT = 2;
    localparam int BUF    = 4;
    localparam int OCC_W  = 7;

    localparam int PTR_W  = AW + 1;
    localparam int BUF_AW = $clog2(BUF);
    localparam int CRED_W = $clog2(BUF + 1);

    // The extra MSB on each pointer separates full (MSBs differ) from empty (identical).
    function automatic logic ptr_full(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    function automatic logic ptr_empty(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp);
        return wp == rp;
    endfunction

endpackage

// File: rtl/tri_fifo_ctl_pfbuf.sv
// Prefetch buffer that catches array read returns and presents the FIFO head.
// It also reports how many more reads may be launched without overflowing it.
module tri_fifo_ctl_pfbuf
    import tri_64x144_fifo_ctl_pkg::*;
(
    input  logic              nclk,
    input  logic              rst_b,
    input  logic              flush,
    input  logic              land,
    input  logic [WIDTH-1:0]  land_data,
    input  logic              take,
    input  logic [CRED_W-1:0] inflight,
    output logic              out_val,
    output logic [WIDTH-1:0]  out_data,
    output logic [CRED_W-1:0] credits
);

    logic [WIDTH-1:0]  mem [BUF];
    logic [BUF_AW-1:0] head;
    logic [BUF_AW-1:0] tail;
    logic [CRED_W-1:0] count;

    assign out_val  = (count != '0);
    assign out_data = mem[head];
    // Reads still travelling through the array pipe already own a buffer slot.
    assign credits  = CRED_W'(BUF) - count - inflight;

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (land) tail <= tail + BUF_AW'(1);
            if (take) head <= head + BUF_AW'(1);
            case ({land, take})
                2'b10:   count <= count + CRED_W'(1);
                2'b01:   count <= count - CRED_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge nclk) begin
        if (land) mem[tail] <= land_data;
    end

endmodule

// File: rtl/tri_64x144_fifo_ctl.sv
// Turns a 64x144 1r1w register file with 2-cycle read latency into a valid/ready FIFO.
// It owns both array ports, tracks reads in flight, and feeds pops from a prefetch buffer.
module tri_64x144_fifo_ctl
    import tri_64x144_fifo_ctl_pkg::*;
(
    input  logic              nclk,
    input  logic              rst_b,
    input  logic              flush,
    input  logic              push_val,
    output logic              push_rdy,
    input  logic [WIDTH-1:0]  push_data,
    output logic              pop_val,
    input  logic              pop_rdy,
    output logic [WIDTH-1:0]  pop_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic              ary_wr_act,
    output logic              ary_write_enable,
    output logic [AW-1:0]     ary_addr_wr,
    output logic [WIDTH-1:0]  ary_data_in,
    output logic              ary_rd_act,
    output logic [AW-1:0]     ary_addr_rd,
    input  logic [WIDTH-1:0]  ary_data_out
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              run;
    logic [RD_LAT-1:0] vld_pipe;
    logic [CRED_W-1:0] inflight;
    logic [CRED_W-1:0] credits;
    logic              push_fire;
    logic              rd_fire;
    logic              pop_fire;
    logic              land;

    // Fullness comes from registered pointers only, so a read launched this cycle never
    // frees the slot being written and the two ports never touch one address together.
    assign push_rdy  = run && !ptr_full(wr_ptr, rd_ptr) && !flush;
    assign push_fire = push_val && push_rdy;
    assign rd_fire   = !ptr_empty(wr_ptr, rd_ptr) && (credits != '0) && !flush;
    assign pop_fire  = pop_val && pop_rdy;
    assign land      = vld_pipe[RD_LAT-1] && !flush;

    assign ary_wr_act       = push_fire;
    assign ary_write_enable = push_fire;
    assign ary_addr_wr      = wr_ptr[AW-1:0];
    assign ary_data_in      = push_data;
    assign ary_rd_act       = rd_fire;
    assign ary_addr_rd      = rd_ptr[AW-1:0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRED_W'(vld_pipe[i]);
        end
    end

    // Holds push_rdy low until the first clock after reset release.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire)   rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // One bit per array pipe stage; the top bit marks data present on ary_data_out now.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b)     vld_pipe <= '0;
        else if (flush) vld_pipe <= '0;
        else            vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_fire};
    end

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (push_fire && !pop_fire) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!push_fire && pop_fire) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    tri_fifo_ctl_pfbuf u_pfbuf (
        .nclk      (nclk),
        .rst_b     (rst_b),
        .flush     (flush),
        .land      (land),
        .land_data (ary_data_out),
        .take      (pop_fire),
        .inflight  (inflight),
        .out_val   (pop_val),
        .out_data  (pop_data),
        .credits   (credits)
    );

endmodule

// File: tb/tb_tri_64x144_fifo_ctl.sv
// Bench for tri_64x144_fifo_ctl: a behavioural 2-cycle register file, a cycle-accurate
// vector table, and scripted fill/stream/flush/reset sequences against a FIFO scoreboard.
module tb_tri_64x144_fifo_ctl;
    import tri_64x144_fifo_ctl_pkg::*;

    logic             nclk = 1'b0;
    logic             rst_b;
    logic             flush;
    logic             push_val;
    logic             push_rdy;
    logic [WIDTH-1:0] push_data;
    logic             pop_val;
    logic             pop_rdy;
    logic [WIDTH-1:0] pop_data;
    logic [OCC_W-1:0] occupancy;
    logic             ary_wr_act;
    logic             ary_write_enable;
    logic [AW-1:0]    ary_addr_wr;
    logic [WIDTH-1:0] ary_data_in;
    logic             ary_rd_act;
    logic [AW-1:0]    ary_addr_rd;
    logic [WIDTH-1:0] ary_data_out;

    always #5 nclk = ~nclk;

    tri_64x144_fifo_ctl dut (
        .nclk             (nclk),
        .rst_b            (rst_b),
        .flush            (flush),
        .push_val         (push_val),
        .push_rdy         (push_rdy),
        .push_data        (push_data),
        .pop_val          (pop_val),
        .pop_rdy          (pop_rdy),
        .pop_data         (pop_data),
        .occupancy        (occupancy),
        .ary_wr_act       (ary_wr_act),
        .ary_write_enable (ary_write_enable),
        .ary_addr_wr      (ary_addr_wr),
        .ary_data_in      (ary_data_in),
        .ary_rd_act       (ary_rd_act),
        .ary_addr_rd      (ary_addr_rd),
        .ary_data_out     (ary_data_out)
    );

    // Register file model: data valid exactly two cycles after the read strobe, all-ones otherwise.
    logic [WIDTH-1:0] ary_mem [DEPTH];
    logic [WIDTH-1:0] rd_s1;
    logic [WIDTH-1:0] rd_s2;
    always @(posedge nclk) begin
        if (ary_write_enable) ary_mem[ary_addr_wr] <= ary_data_in;
        rd_s1 <= ary_rd_act ? ary_mem[ary_addr_rd] : {WIDTH{1'b1}};
        rd_s2 <= rd_s1;
    end
    assign ary_data_out = rd_s2;

    int cyc = 0;
    always @(posedge nclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chkw(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted push must pop exactly once, in order; occupancy tracks +push -pop.
    logic [WIDTH-1:0] sb [$];
    int occ_m   = 0;
    int pop_cnt = 0;

    always @(negedge nclk) begin
        logic pf;
        logic qf;
        if (!rst_b) begin
            sb.delete();
            occ_m = 0;
        end else begin
            pf = push_val && push_rdy;
            qf = pop_val && pop_rdy;
            chkw("occupancy", WIDTH'(occupancy), WIDTH'(occ_m));
            chk1("wr_act", ary_wr_act, pf);
            chk1("write_enable", ary_write_enable, pf);
            if (pf) chkw("data_in", ary_data_in, push_data);
            if (ary_write_enable && ary_rd_act)
                chk1("rw_same_addr", ary_addr_wr == ary_addr_rd, 1'b0);
            if (qf) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL pop_underflow: pop of %0h with nothing queued (cycle %0d)", pop_data, cyc);
                end else begin
                    chkw("pop_data", pop_data, sb.pop_front());
                end
                pop_cnt++;
            end
            if (pf) sb.push_back(push_data);
            if (flush) begin
                sb.delete();
                occ_m = 0;
            end else begin
                occ_m = occ_m + int'(pf) - int'(qf);
            end
            chk1("occ_limit", occ_m <= DEPTH + BUF, 1'b1);
        end
    end

    typedef struct {
        logic             push_val;
        logic [WIDTH-1:0] push_data;
        logic             pop_rdy;
        logic             e_push_rdy;
        logic             e_pop_val;
        logic [WIDTH-1:0] e_pop_data;
        logic [OCC_W-1:0] e_occ;
        logic             e_wr;
        logic [AW-1:0]    e_waddr;
        logic             e_rd;
        logic [AW-1:0]    e_raddr;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic set_vec(input int i, input int pv, input int pd, input int pr,
                           input int prdy, input int pval, input int pdat, input int occ,
                           input int wr, input int wa, input int rd, input int ra);
        tbl[i].push_val   = (pv != 0);
        tbl[i].push_data  = WIDTH'(pd);
        tbl[i].pop_rdy    = (pr != 0);
        tbl[i].e_push_rdy = (prdy != 0);
        tbl[i].e_pop_val  = (pval != 0);
        tbl[i].e_pop_data = WIDTH'(pdat);
        tbl[i].e_occ      = OCC_W'(occ);
        tbl[i].e_wr       = (wr != 0);
        tbl[i].e_waddr    = AW'(wa);
        tbl[i].e_rd       = (rd != 0);
        tbl[i].e_raddr    = AW'(ra);
    endtask

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    // Entered just after a rising edge with an empty, freshly reset FIFO.
    task automatic run_table(input string tag);
        for (int i = 0; i < NV; i++) begin
            push_val  = tbl[i].push_val;
            push_data = tbl[i].push_data;
            pop_rdy   = tbl[i].pop_rdy;
            @(negedge nclk);
            chk1($sformatf("%s_v%0d_push_rdy", tag, i), push_rdy, tbl[i].e_push_rdy);
            chk1($sformatf("%s_v%0d_pop_val", tag, i), pop_val, tbl[i].e_pop_val);
            if (tbl[i].e_pop_val) chkw($sformatf("%s_v%0d_pop_data", tag, i), pop_data, tbl[i].e_pop_data);
            chkw($sformatf("%s_v%0d_occ", tag, i), WIDTH'(occupancy), WIDTH'(tbl[i].e_occ));
            chk1($sformatf("%s_v%0d_wr", tag, i), ary_write_enable, tbl[i].e_wr);
            if (tbl[i].e_wr) chkw($sformatf("%s_v%0d_waddr", tag, i), WIDTH'(ary_addr_wr), WIDTH'(tbl[i].e_waddr));
            chk1($sformatf("%s_v%0d_rd", tag, i), ary_rd_act, tbl[i].e_rd);
            if (tbl[i].e_rd) chkw($sformatf("%s_v%0d_raddr", tag, i), WIDTH'(ary_addr_rd), WIDTH'(tbl[i].e_raddr));
            tick();
        end
        push_val = 1'b0;
        pop_rdy  = 1'b0;
    endtask

    initial begin
        int nv;
        int rdp;
        int p0;
        int first_push;
        int first_pop;
        int last_pop;

        //       i  pv pd     pr  prdy pval pdat   occ wr wa rd ra
        set_vec( 0, 1, 'hA5, 1,  1,   0,   0,     0,  1, 0, 0, 0);
        set_vec( 1, 0, 0,    1,  1,   0,   0,     1,  0, 0, 1, 0);
        set_vec( 2, 0, 0,    1,  1,   0,   0,     1,  0, 0, 0, 0);
        set_vec( 3, 0, 0,    1,  1,   0,   0,     1,  0, 0, 0, 0);
        set_vec( 4, 0, 0,    1,  1,   1,   'hA5,  1,  0, 0, 0, 0);
        set_vec( 5, 1, 'hB1, 0,  1,   0,   0,     0,  1, 1, 0, 0);
        set_vec( 6, 1, 'hB2, 0,  1,   0,   0,     1,  1, 2, 1, 1);
        set_vec( 7, 0, 0,    0,  1,   0,   0,     2,  0, 0, 1, 2);
        set_vec( 8, 0, 0,    0,  1,   0,   0,     2,  0, 0, 0, 0);
        set_vec( 9, 0, 0,    0,  1,   1,   'hB1,  2,  0, 0, 0, 0);
        set_vec(10, 0, 0,    1,  1,   1,   'hB1,  2,  0, 0, 0, 0);
        set_vec(11, 1, 'hC3, 1,  1,   1,   'hB2,  1,  1, 3, 0, 0);
        set_vec(12, 0, 0,    1,  1,   0,   0,     1,  0, 0, 1, 3);
        set_vec(13, 0, 0,    1,  1,   0,   0,     1,  0, 0, 0, 0);
        set_vec(14, 0, 0,    1,  1,   0,   0,     1,  0, 0, 0, 0);
        set_vec(15, 0, 0,    1,  1,   1,   'hC3,  1,  0, 0, 0, 0);
        set_vec(16, 0, 0,    1,  1,   0,   0,     0,  0, 0, 0, 0);

        rst_b     = 1'b0;
        flush     = 1'b0;
        push_val  = 1'b1;
        push_data = '0;
        pop_rdy   = 1'b0;
        #3;
        chk1("rst_push_rdy", push_rdy, 1'b0);
        chk1("rst_pop_val", pop_val, 1'b0);
        chkw("rst_occ", WIDTH'(occupancy), '0);
        chk1("rst_wr", ary_write_enable, 1'b0);
        chk1("rst_rd", ary_rd_act, 1'b0);
        push_val = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        tick();

        run_table("t1");

        // Fill with consumer stalled: 64 in the array plus 4 prefetched.
        nv  = 0;
        rdp = 0;
        for (int c = 0; c < 75; c++) begin
            push_val  = 1'b1;
            push_data = WIDTH'(nv);
            @(negedge nclk);
            if (push_rdy) nv++;
            if (ary_rd_act) rdp++;
            tick();
        end
        push_val = 1'b0;
        @(negedge nclk);
        chkw("fill_accepts", WIDTH'(nv), WIDTH'(DEPTH + BUF));
        chkw("fill_reads", WIDTH'(rdp), WIDTH'(BUF));
        chkw("fill_occ", WIDTH'(occupancy), WIDTH'(DEPTH + BUF));
        chk1("fill_push_rdy", push_rdy, 1'b0);
        tick();
        p0      = pop_cnt;
        pop_rdy = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge nclk);
            tick();
        end
        chkw("drain_pops", WIDTH'(pop_cnt - p0), WIDTH'(DEPTH + BUF));
        chkw("drain_occ", WIDTH'(occupancy), '0);

        // Streaming: one push and one pop per cycle across several pointer wraps.
        nv         = 0;
        p0         = pop_cnt;
        first_push = -1;
        first_pop  = -1;
        last_pop   = -1;
        for (int c = 0; c < 400 && (nv < 200 || pop_cnt - p0 < 200); c++) begin
            push_val  = (nv < 200);
            push_data = WIDTH'(32'h1000 + nv);
            @(negedge nclk);
            if (push_val && push_rdy) begin
                if (first_push < 0) first_push = cyc;
                nv++;
            end
            if (pop_val && pop_rdy) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            tick();
        end
        push_val = 1'b0;
        chkw("stream_pops", WIDTH'(pop_cnt - p0), WIDTH'(200));
        chkw("stream_first_latency", WIDTH'(first_pop - first_push), WIDTH'(RD_LAT + 2));
        chkw("stream_pop_span", WIDTH'(last_pop - first_pop), WIDTH'(199));

        // Random consumer backpressure with a continuous producer.
        nv = 0;
        p0 = pop_cnt;
        for (int c = 0; c < 3000 && (nv < 300 || pop_cnt - p0 < 300); c++) begin
            push_val  = (nv < 300);
            push_data = WIDTH'(32'h2000 + nv);
            pop_rdy   = 1'($urandom_range(0, 1));
            @(negedge nclk);
            if (push_val && push_rdy) nv++;
            tick();
        end
        push_val = 1'b0;
        pop_rdy  = 1'b0;
        chkw("random_pops", WIDTH'(pop_cnt - p0), WIDTH'(300));
        @(negedge nclk);
        chkw("random_occ", WIDTH'(occupancy), '0);
        tick();

        // Flush right after three reads went out; late returns must vanish.
        for (int k = 0; k < 11; k++) begin
            push_val  = (k <= 5);
            push_data = WIDTH'((k == 5) ? 32'h77 : 32'hF0 + k);
            flush     = (k == 4);
            pop_rdy   = (k >= 9);
            @(negedge nclk);
            if (k == 3) chk1("flush_third_read", ary_rd_act, 1'b1);
            if (k == 4) begin
                chk1("flush_push_rdy", push_rdy, 1'b0);
                chk1("flush_wr", ary_write_enable, 1'b0);
                chk1("flush_rd", ary_rd_act, 1'b0);
            end
            if (k >= 5 && k <= 8) chk1($sformatf("flush_k%0d_pop_val", k), pop_val, 1'b0);
            if (k == 5) begin
                chkw("flush_occ", WIDTH'(occupancy), '0);
                chkw("flush_waddr", WIDTH'(ary_addr_wr), '0);
            end
            if (k == 9) begin
                chk1("flush_repush_pop_val", pop_val, 1'b1);
                chkw("flush_repush_data", pop_data, WIDTH'(32'h77));
            end
            tick();
        end
        push_val = 1'b0;
        flush    = 1'b0;
        pop_rdy  = 1'b0;

        // Asynchronous reset in the middle of a stream.
        pop_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_val  = 1'b1;
            push_data = WIDTH'(32'h3000 + k);
            @(negedge nclk);
            tick();
        end
        push_val  = 1'b1;
        push_data = WIDTH'(32'h3008);
        #2;
        rst_b = 1'b0;
        #1;
        chk1("arst_push_rdy", push_rdy, 1'b0);
        chk1("arst_pop_val", pop_val, 1'b0);
        chkw("arst_occ", WIDTH'(occupancy), '0);
        chk1("arst_wr", ary_write_enable, 1'b0);
        chk1("arst_wr_act", ary_wr_act, 1'b0);
        chk1("arst_rd", ary_rd_act, 1'b0);
        push_val = 1'b0;
        pop_rdy  = 1'b0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        tick();

        run_table("t2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
